// File: rtl/decimal_key_debouncer.sv
// Debounces ten raw decimal key lines into a registered one-hot key code.
// A press is accepted only when exactly one key is stable for DEBOUNCE_CYCLES.
module decimal_key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] Keys,
    output logic [9:0] Decimal,
    output logic       Valid,
    output logic       Key_down,
    output logic       Multi_key
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Comparing against DEBOUNCE_CYCLES-1 avoids a 17-bit CNT+1 at the top of the range.
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [9:0]  sync1_q;
    logic [9:0]  sync_q;
    state_e      state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [9:0]  cand_q,      cand_d;
    logic [9:0]  decimal_q,   decimal_d;
    logic        valid_q,     valid_d;
    logic        key_down_q,  key_down_d;
    logic        multi_key_q, multi_key_d;

    logic        s_zero;
    logic        s_multi;
    logic        s_one_hot;

    assign s_zero    = (sync_q == 10'd0);
    assign s_multi   = ((sync_q & (sync_q - 10'd1)) != 10'd0);
    assign s_one_hot = !s_zero && !s_multi;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        decimal_d   = decimal_q;
        valid_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s_one_hot) begin
                    cand_d  = sync_q;
                    cnt_d   = 16'd1;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sync_q == cand_q) begin
                    if (cnt_q == CNT_LAST) begin
                        decimal_d = cand_q;
                        valid_d   = 1'b1;
                        cnt_d     = 16'd0;
                        state_d   = PRESSED;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end
            end
            PRESSED: begin
                // Any nonzero pattern keeps the held key; new keys wait for a full release.
                if (s_zero) begin
                    cnt_d   = 16'd1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (s_zero) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = 16'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d   = 16'd0;
                    state_d = PRESSED;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = IDLE;
            end
        endcase

        key_down_d  = (state_d == PRESSED) || (state_d == RELEASE);
        multi_key_d = s_multi;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 10'd0;
            sync_q      <= 10'd0;
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            cand_q      <= 10'd0;
            decimal_q   <= 10'b0000000001;
            valid_q     <= 1'b0;
            key_down_q  <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            sync1_q     <= Keys;
            sync_q      <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            decimal_q   <= decimal_d;
            valid_q     <= valid_d;
            key_down_q  <= key_down_d;
            multi_key_q <= multi_key_d;
        end
    end

    assign Decimal   = decimal_q;
    assign Valid     = valid_q;
    assign Key_down  = key_down_q;
    assign Multi_key = multi_key_q;

endmodule

// File: tb/tb_decimal_key_debouncer.sv
// Scoreboard bench for decimal_key_debouncer with DEBOUNCE_CYCLES=4: stimulus
// pushes expected Valid events, a negedge monitor pops and compares them.
module tb_decimal_key_debouncer;

    localparam int DC = 4;

    typedef struct {
        logic [9:0] dec;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [9:0] keys;
    logic [9:0] decimal;
    logic       valid;
    logic       key_down;
    logic       multi_key;

    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    decimal_key_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Keys      (keys),
        .Decimal   (decimal),
        .Valid     (valid),
        .Key_down  (key_down),
        .Multi_key (multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive point: just after rising edge k.
    task automatic after_edge(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sample point: falling edge following rising edge k.
    task automatic sample_after(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic expect_valid(input logic [9:0] dec, input int at_cyc);
        exp_t e;
        e.dec = dec;
        e.cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    // Monitor: every Valid pulse must match the oldest expected press.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(decimal), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_decimal", 32'(decimal), 32'(e.dec));
                check("valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    localparam logic [9:0] K2 = 10'b0000000100;
    localparam logic [9:0] K3 = 10'b0000001000;
    localparam logic [9:0] K5 = 10'b0000100000;
    localparam logic [9:0] K7 = 10'b0010000000;
    localparam logic [9:0] K9 = 10'b1000000000;
    localparam logic [9:0] RST_DEC = 10'b0000000001;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        keys     = 10'd0;

        // Reset state
        sample_after(1);
        check("rst_decimal", 32'(decimal), 32'(RST_DEC));
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_key_down", 32'(key_down), 32'h0);
        check("rst_multi", 32'(multi_key), 32'h0);
        after_edge(3);
        rst_n = 1'b1;

        // Two keys at once: flagged, never accepted
        after_edge(5);
        keys = 10'b0000010010;
        sample_after(7);
        check("multi_before", 32'(multi_key), 32'h0);
        sample_after(8);
        check("multi_set", 32'(multi_key), 32'h1);
        sample_after(25);
        check("multi_held", 32'(multi_key), 32'h1);
        check("multi_decimal", 32'(decimal), 32'(RST_DEC));
        check("multi_key_down", 32'(key_down), 32'h0);
        keys = 10'd0;
        sample_after(28);
        check("multi_clear", 32'(multi_key), 32'h0);

        // Clean press of key 5: Valid after edge N+DC+2
        after_edge(30);
        keys = K5;
        expect_valid(K5, 30 + DC + 2);
        sample_after(35);
        check("k5_key_down_pre", 32'(key_down), 32'h0);
        sample_after(36);
        check("k5_key_down", 32'(key_down), 32'h1);
        sample_after(37);
        check("k5_decimal_hold", 32'(decimal), 32'(K5));
        after_edge(40);
        keys = 10'd0;
        sample_after(45);
        check("k5_release_hold", 32'(key_down), 32'h1);
        sample_after(46);
        check("k5_release_done", 32'(key_down), 32'h0);

        // Bouncing key 2: high 2, low 1, then stable
        after_edge(50);
        keys = K2;
        after_edge(52);
        keys = 10'd0;
        after_edge(53);
        keys = K2;
        expect_valid(K2, 53 + DC + 2);
        sample_after(60);
        check("k2_key_down", 32'(key_down), 32'h1);
        check("k2_decimal", 32'(decimal), 32'(K2));

        // Key 7 joins while key 2 is held, then key 2 lifts: nothing new accepted
        after_edge(62);
        keys = K2 | K7;
        sample_after(70);
        check("k7_over_k2_dec", 32'(decimal), 32'(K2));
        check("k7_over_k2_multi", 32'(multi_key), 32'h1);
        keys = K7;
        sample_after(78);
        check("k7_alone_dec", 32'(decimal), 32'(K2));
        check("k7_alone_key_down", 32'(key_down), 32'h1);
        keys = 10'd0;
        sample_after(84);
        check("k7_released", 32'(key_down), 32'h0);
        after_edge(86);
        keys = K7;
        expect_valid(K7, 86 + DC + 2);
        after_edge(95);
        keys = 10'd0;

        // Key 3 with a short release gap: one Valid, Key_down stays high
        after_edge(105);
        keys = K3;
        expect_valid(K3, 105 + DC + 2);
        after_edge(115);
        keys = 10'd0;
        after_edge(117);
        keys = K3;
        sample_after(118);
        check("k3_gap_a", 32'(key_down), 32'h1);
        sample_after(119);
        check("k3_gap_b", 32'(key_down), 32'h1);
        sample_after(120);
        check("k3_gap_c", 32'(key_down), 32'h1);
        after_edge(125);
        keys = 10'd0;
        sample_after(130);
        check("k3_final_hold", 32'(key_down), 32'h1);
        check("k3_decimal", 32'(decimal), 32'(K3));
        sample_after(131);
        check("k3_final_drop", 32'(key_down), 32'h0);

        // Reset during DEBOUNCE of key 9, key kept held afterwards
        after_edge(135);
        keys = K9;
        after_edge(139);
        rst_n = 1'b0;
        #1;
        check("midrst_decimal", 32'(decimal), 32'(RST_DEC));
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_key_down", 32'(key_down), 32'h0);
        check("midrst_multi", 32'(multi_key), 32'h0);
        after_edge(141);
        rst_n = 1'b1;
        expect_valid(K9, 141 + DC + 2);
        sample_after(146);
        check("k9_key_down_pre", 32'(key_down), 32'h0);
        sample_after(147);
        check("k9_key_down", 32'(key_down), 32'h1);
        after_edge(150);
        keys = 10'd0;

        sample_after(160);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        check("final_decimal", 32'(decimal), 32'(K9));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decimal_key_debouncer.md
DECIMAL_KEY_DEBOUNCER -- requirements
Module: decimal_key_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, meaning: consecutive stable synchronized cycles required to accept a press or release; legal range 2..65535.
REQ-002 Port clk  input  1  single rising-edge clock for all state.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port Keys  input  10  raw asynchronous key lines, bit k high = decimal key k pressed.
REQ-005 Port Decimal  output  10  registered one-hot code of last accepted key; feeds the downstream one-hot-to-binary encoder.
REQ-006 Port Valid  output  1  one-cycle pulse when Decimal is loaded with a newly accepted key.
REQ-007 Port Key_down  output  1  high while an accepted key is held, including its release-debounce window.
REQ-008 Port Multi_key  output  1  registered flag, high while the synchronized key vector has more than one bit set.

Function
REQ-009 Keys SHALL pass through a 2-flop synchronizer per bit; all decisions use the synchronized vector S.
REQ-010 FSM SHALL have exactly four states: IDLE, DEBOUNCE, PRESSED, RELEASE; 16-bit counter CNT; 10-bit candidate register CAND.
REQ-011 IDLE: S one-hot -> CAND<=S, CNT<=1, go DEBOUNCE; S zero or multi-hot -> stay IDLE.
REQ-012 DEBOUNCE: S==CAND -> CNT<=CNT+1; on the edge where CNT+1 would equal DEBOUNCE_CYCLES, load Decimal<=CAND, pulse Valid, go PRESSED, CNT<=0.
REQ-013 DEBOUNCE: S!=CAND (any change, including zero or multi-hot) -> go IDLE, CNT<=0, no Valid, Decimal unchanged.
REQ-014 PRESSED: S zero -> go RELEASE, CNT<=1; S nonzero (same, different, or multi-hot) -> stay PRESSED; no new key accepted until release completes.
REQ-015 RELEASE: S zero -> CNT<=CNT+1; on the edge where CNT+1 would equal DEBOUNCE_CYCLES go IDLE, CNT<=0; S nonzero -> back to PRESSED, CNT<=0.
REQ-016 Latency: key raw-stable from sampling edge 1 -> Valid high in the cycle after edge DEBOUNCE_CYCLES+2.
REQ-017 Valid SHALL be high for exactly one cycle per accepted press, never two pulses without an intervening completed RELEASE.
REQ-018 Decimal SHALL hold its value between Valid pulses and SHALL always be exactly one-hot.
REQ-019 Key_down SHALL be high iff state is PRESSED or RELEASE (registered, same cycle as state).
REQ-020 Multi_key SHALL be registered from S (popcount(S)>1), independent of state, one cycle after S.
REQ-021 CNT SHALL never wrap; it saturates logic by leaving the counting state at DEBOUNCE_CYCLES.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, CNT 0, CAND 0, synchronizer flops 0, Decimal 10'b0000000001, Valid 0, Key_down 0, Multi_key 0.
REQ-023 Reset asserted mid-DEBOUNCE or mid-PRESSED SHALL discard the press with no Valid pulse; after rst_n rises a key still held is re-debounced from IDLE.
REQ-024 Reset deassertion SHALL be sampled on a clk rising edge; first state change no earlier than the first edge after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Keys=10'b0000100000 held from edge 1 -> Valid pulse in cycle after edge 6, Decimal=10'b0000100000, Key_down=1.
REQ-026 Keys=10'b0000000100 bouncing (high 2 cycles, low 1, then stable) -> exactly one Valid, Decimal=10'b0000000100, Valid timed from last stable start.
REQ-027 Keys=10'b0000010010 held 20 cycles -> Multi_key=1, no Valid, Decimal stays 10'b0000000001.
REQ-028 Key 3 accepted, released 2 cycles then re-pressed, released for good -> one Valid only; Key_down falls 4 cycles after S goes zero.
REQ-029 rst_n pulsed low during DEBOUNCE of key 9 -> all outputs reset values immediately, no Valid; key still held after release -> Valid with Decimal=10'b1000000000 after 6 further edges.
REQ-030 Key 7 pressed while key 2 held (PRESSED) -> no Valid, Decimal remains 10'b0000000100 until full release and new press.
